vx_cache_flush_seq: RTL



---
 rtl/vx_cache_flush_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vx_cache_flush_seq.sv
// Cache tag maintenance sequencer: walks every line once after reset (tag init) and on each flush request (tag flush), then waits for the pipeline to drain and signals completion.
// Latency: one op per cycle while seq_ready=1; the response follows the first pipe_idle cycle after the last op is accepted.
// Backpressure: seq_ready=0 stalls the walk with all seq_* outputs held; flush_rsp_valid is held until flush_rsp_ready.
// Optional: define VX_CACHE_FLUSH_PERF_EN to add the perf_flush_cycles counter port.
module vx_cache_flush_seq #(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 16,
    parameter int NUM_BANKS  = 1,
    parameter int NUM_WAYS   = 1,
    parameter int WRITEBACK  = 0,
    localparam int LINES     = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
    localparam int LSB       = (LINES > 2) ? $clog2(LINES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_req_valid,
    output logic                flush_req_ready,
    output logic                flush_rsp_valid,
    input  logic                flush_rsp_ready,
    output logic                seq_valid,
    input  logic                seq_ready,
    output logic                seq_init,
    output logic                seq_flush,
    output logic [LSB-1:0]      seq_line_sel,
    output logic [NUM_WAYS-1:0] seq_way_sel,
    input  logic                pipe_idle,
    output logic                busy
`ifdef VX_CACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]         perf_flush_cycles
`endif
);

    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [LSB-1:0]   LAST_LINE = LSB'(LINES - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FLUSH,
        ST_DRAIN,
        ST_RESP
    } state_t;

    state_t           state, state_n;
    logic [LSB-1:0]   line_ctr, line_n;
    logic [WAY_W-1:0] way_ctr, way_n;
    logic             last_way;

    // State and walk counters; reset restarts the init walk at line 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            line_ctr <= '0;
            way_ctr  <= '0;
        end else begin
            state    <= state_n;
            line_ctr <= line_n;
            way_ctr  <= way_n;
        end
    end

    // Next-state, counter advance and op outputs; outputs depend only on registered state so they hold during stalls
    always_comb begin
        state_n         = state;
        line_n          = line_ctr;
        way_n           = way_ctr;
        flush_req_ready = 1'b0;
        flush_rsp_valid = 1'b0;
        seq_valid       = 1'b0;
        seq_init        = 1'b0;
        seq_flush       = 1'b0;
        seq_line_sel    = line_ctr;
        seq_way_sel     = '1;
        // Without writeback every op covers all ways, so the way loop collapses to one step
        last_way        = (WRITEBACK == 0) || (way_ctr == LAST_WAY);

        case (state)
            ST_INIT: begin
                seq_valid = 1'b1;
                seq_init  = 1'b1;
                if (seq_ready) begin
                    if (line_ctr == LAST_LINE) begin
                        line_n  = '0;
                        state_n = ST_IDLE;
                    end else begin
                        line_n = line_ctr + LSB'(1);
                    end
                end
            end
            ST_IDLE: begin
                flush_req_ready = 1'b1;
                if (flush_req_valid) begin
                    line_n  = '0;
                    way_n   = '0;
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                seq_valid = 1'b1;
                seq_flush = 1'b1;
                if (WRITEBACK != 0) begin
                    seq_way_sel = NUM_WAYS'(1) << way_ctr;
                end
                if (seq_ready) begin
                    if (last_way) begin
                        way_n = '0;
                        if (line_ctr == LAST_LINE) begin
                            line_n  = '0;
                            state_n = ST_DRAIN;
                        end else begin
                            line_n = line_ctr + LSB'(1);
                        end
                    end else begin
                        way_n = way_ctr + WAY_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_idle) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                flush_rsp_valid = 1'b1;
                if (flush_rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

`ifdef VX_CACHE_FLUSH_PERF_EN
    // Cycles spent servicing flushes (walk, drain, response); saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_flush_cycles <= '0;
        end else if ((state == ST_FLUSH || state == ST_DRAIN || state == ST_RESP)
                     && (perf_flush_cycles != '1)) begin
            perf_flush_cycles <= perf_flush_cycles + 32'd1;
        end
    end
`endif

endmodule
